// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic operand feeder.
//   state_e       - tile sequencing states
//   drain_cycles  - cycles needed to flush an n x n array after the last beat
//   lane_lsb      - bit offset of a lane inside a packed multi-lane bus
package systolic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StDone
    } state_e;

    // Worst lane skew (n-1) + corner PE hop (n-1) + PE accumulator register (1).
    function automatic int unsigned drain_cycles(input int unsigned n);
        return 2 * n - 1;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: one operand lane, DEPTH-stage shift register, cleared by reset.
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; clears every stage
//   d_in   - value entering stage 0 this cycle
//   d_out  - value leaving the last stage (d_in delayed DEPTH cycles)
module skew_delay_line #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] d_in,
    output logic [DATA_SIZE-1:0] d_out
);

    logic [DEPTH-1:0][DATA_SIZE-1:0] stage_q;
    logic [DEPTH-1:0][DATA_SIZE-1:0] stage_d;

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: operand feeder in front of an N x N MAC array.
// Takes one N-lane A column and one N-lane B row per accepted beat and skews
// them diagonally (lane i gets i+1 register stages) onto the array edges.
// Sequences a tile: clear PEs, stream k_len beats, drain the array, pulse done.
//   clk, reset        - clock, asynchronous active-high reset
//   start, k_len      - begin a tile of k_len beats (sampled in idle only)
//   in_valid/in_ready - beat handshake for in_a / in_b
//   in_a, in_b        - N lanes of DATA_SIZE bits, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   out_a, out_b      - skewed lanes to array row / column inputs
//   pe_clear          - synchronous accumulator clear to all PEs
//   busy              - high in every state except idle
//   done              - one-cycle pulse once tile results are final
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned N         = 16,
    parameter int unsigned K_MAX     = 16,
    parameter int unsigned KW        = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_SIZE-1:0] in_a,
    input  logic [N*DATA_SIZE-1:0] in_b,
    output logic [N*DATA_SIZE-1:0] out_a,
    output logic [N*DATA_SIZE-1:0] out_b,
    output logic                  pe_clear,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DrainCycles = drain_cycles(N);
    localparam int unsigned DcW         = $clog2(DrainCycles + 1);

    state_e         state_q, state_d;
    logic [KW-1:0]  beats_left_q, beats_left_d;
    logic [DcW-1:0] drain_cnt_q, drain_cnt_d;
    logic           pe_clear_q, pe_clear_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic                   accept;
    logic [N*DATA_SIZE-1:0] feed_a;
    logic [N*DATA_SIZE-1:0] feed_b;

    // in_ready_q is only ever high in stream with beats outstanding.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        drain_cnt_d  = drain_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start && (k_len != '0)) begin
                    state_d      = StClear;
                    beats_left_d = k_len;
                end
            end
            StClear: state_d = StStream;
            StStream: begin
                if (accept) begin
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == KW'(1)) begin
                        state_d     = StDrain;
                        drain_cnt_d = DcW'(DrainCycles - 1);
                    end
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered: decode them from the next state.
        pe_clear_d = (state_d == StClear);
        in_ready_d = (state_d == StStream);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            beats_left_q <= '0;
            drain_cnt_q  <= '0;
            pe_clear_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            drain_cnt_q  <= drain_cnt_d;
            pe_clear_q   <= pe_clear_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Zeros enter the lanes on every cycle without an accepted beat, so they
    // contribute nothing to the PE accumulators.
    assign feed_a = accept ? in_a : '0;
    assign feed_b = accept ? in_b : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int unsigned Lsb = lane_lsb(i, DATA_SIZE);

        skew_delay_line #(
            .DATA_SIZE(DATA_SIZE),
            .DEPTH    (i + 1)
        ) u_skew_a (
            .clk  (clk),
            .reset(reset),
            .d_in (feed_a[Lsb +: DATA_SIZE]),
            .d_out(out_a[Lsb +: DATA_SIZE])
        );

        skew_delay_line #(
            .DATA_SIZE(DATA_SIZE),
            .DEPTH    (i + 1)
        ) u_skew_b (
            .clk  (clk),
            .reset(reset),
            .d_in (feed_b[Lsb +: DATA_SIZE]),
            .d_out(out_b[Lsb +: DATA_SIZE])
        );
    end

    assign in_ready = in_ready_q;
    assign pe_clear = pe_clear_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
